apb_resp_mux: RTL and testbench
===============================

APB_RESP_MUX -- requirements
Module: apb_resp_mux

Interface
REQ-001 Parameter NSLV, default 2: number of APB slaves on the bus, range 1..8.
REQ-002 Parameter TIMEOUT, default 16: maximum ACCESS wait cycles before abort, range 2..255.
REQ-003 PCLK  input  1  single system clock; all state on rising edge.
REQ-004 PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 PSEL  input  1  master select, unqualified.
REQ-006 PENABLE  input  1  master access phase.
REQ-007 PSEL_S  input  NSLV  one-hot slave selects from the address decoder.
REQ-008 PREADY_S  input  NSLV  per-slave ready.
REQ-009 PSLVERR_S  input  NSLV  per-slave error.
REQ-010 PRDATA_S  input  32*NSLV  per-slave read data, slave i at bits [32i+31:32i].
REQ-011 PSEL_G  output  NSLV  gated slave selects driven to the slaves.
REQ-012 PREADY  output  1  ready returned to master.
REQ-013 PSLVERR  output  1  error returned to master.
REQ-014 PRDATA  output  32  read data returned to master.
REQ-015 TO_PULSE  output  1  one-cycle pulse on timeout abort.
REQ-016 ERR_CNT  output  8  saturating count of decode errors plus timeouts.

Function
REQ-017 FSM states: IDLE, ACCESS, ABORT; state held in flops.
REQ-018 IDLE: PSEL=1, PENABLE=0 (SETUP) -> register slave index from PSEL_S and DECERR = (PSEL_S==0 or PSEL_S not one-hot); next state ACCESS.
REQ-019 PSEL_G = PSEL_S & {NSLV{PSEL}} in IDLE and ACCESS; forced all-zero in ABORT and whenever DECERR is set.
REQ-020 ACCESS with DECERR: PREADY=1, PSLVERR=1, PRDATA=0 in the first cycle with PENABLE=1 (zero wait states); next state IDLE.
REQ-021 ACCESS without DECERR: PREADY=PREADY_S[idx], PSLVERR=PREADY_S[idx]&PSLVERR_S[idx], PRDATA=PRDATA_S[idx] (combinational mux on registered index).
REQ-022 Wait counter (8 bit) cleared on entry to ACCESS; incremented each ACCESS cycle with PENABLE=1 and PREADY_S[idx]=0.
REQ-023 Wait counter == TIMEOUT while PREADY_S[idx]=0 -> PREADY=1, PSLVERR=1, PRDATA=0, TO_PULSE=1 that cycle; next state ABORT.
REQ-024 Slave ready in the same cycle counter reaches TIMEOUT -> slave response wins; no timeout, no TO_PULSE.
REQ-025 ACCESS with PREADY=1 (any cause) -> IDLE next cycle; back-to-back SETUP in that next cycle is accepted per REQ-018.
REQ-026 ABORT: PSEL_G=0, PREADY=0, PSLVERR=0; exit to IDLE when PSEL=0 or PENABLE=0 (master started new transfer); a SETUP seen in the exit cycle is captured per REQ-018.
REQ-027 PSEL or PENABLE dropping during ACCESS (protocol violation) -> IDLE next cycle, counter cleared, no error counted.
REQ-028 PREADY, PSLVERR, PRDATA, TO_PULSE are 0 whenever not in ACCESS with PSEL&PENABLE=1.
REQ-029 ERR_CNT += 1 on each DECERR completion and each timeout; saturates at 255, never wraps.
REQ-030 Slave PSLVERR with PREADY does not increment ERR_CNT.

Reset
REQ-031 PRESETn low -> state IDLE, index 0, DECERR 0, wait counter 0, ERR_CNT 0, immediately (asynchronous).
REQ-032 All outputs 0 while PRESETn low; PSEL_G forced 0 during reset.
REQ-033 Reset asserted mid-ACCESS or mid-ABORT aborts silently: no TO_PULSE, no ERR_CNT change.
REQ-034 First SETUP is accepted on the first rising PCLK after PRESETn deasserts.

Verification
REQ-035 Read slave 1, PSEL_S=2'b10, PREADY_S[1] high after 2 waits, PRDATA_S slave1=32'hA5A5_0001 -> PREADY on 3rd ACCESS cycle, PRDATA=32'hA5A5_0001, PSLVERR=0, ERR_CNT=0.
REQ-036 Access with PSEL_S=2'b00 -> PREADY=1, PSLVERR=1, PRDATA=0 on first ACCESS cycle, PSEL_G=0 throughout, ERR_CNT=1.
REQ-037 Slave 0 never ready, TIMEOUT=16 -> PREADY=PSLVERR=TO_PULSE=1 on the 17th ACCESS cycle, PSEL_G[0]=0 next cycle, ERR_CNT increments by 1.
REQ-038 Slave ready in the exact timeout cycle -> normal completion, TO_PULSE=0, ERR_CNT unchanged.
REQ-039 260 consecutive decode errors -> ERR_CNT=255 and holds at 255.
REQ-040 PRESETn pulsed low in the 5th wait cycle -> all outputs 0 immediately, ERR_CNT=0, new transfer after release completes normally.

Source files
------------

// File: rtl/apb_resp_mux.sv
// APB response multiplexer: gates slave selects, muxes the selected slave's response back
// to the master, answers decode errors itself and aborts transfers that wait too long.
module apb_resp_mux #(
    parameter int NSLV    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [NSLV-1:0]      PSEL_S,
    input  logic [NSLV-1:0]      PREADY_S,
    input  logic [NSLV-1:0]      PSLVERR_S,
    input  logic [32*NSLV-1:0]   PRDATA_S,
    output logic [NSLV-1:0]      PSEL_G,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic [31:0]          PRDATA,
    output logic                 TO_PULSE,
    output logic [7:0]           ERR_CNT
);
    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ABORT} state_t;

    state_t                 r_state, w_state_nxt;
    logic [IW-1:0]          r_idx, w_idx_nxt;
    logic                   r_decerr, w_decerr_nxt;
    logic [7:0]             r_wcnt, w_wcnt_nxt;
    logic [7:0]             r_err_cnt;
    logic                   w_err_inc;
    logic [IW-1:0]          w_setup_idx;
    logic                   w_setup_decerr;
    logic                   w_setup;
    logic                   w_active;
    logic                   w_sel_rdy;
    logic                   w_sel_err;
    logic [NSLV-1:0][31:0]  w_rdata;
    logic [31:0]            w_sel_data;

    assign w_rdata    = PRDATA_S;
    assign w_setup    = PSEL && !PENABLE;
    assign w_active   = PSEL && PENABLE;
    assign w_sel_rdy  = PREADY_S[r_idx];
    assign w_sel_err  = PREADY_S[r_idx] & PSLVERR_S[r_idx];
    assign w_sel_data = w_rdata[r_idx];

    // Anything other than exactly one select bit is a decode error.
    assign w_setup_decerr = (PSEL_S == '0) || ((PSEL_S & (PSEL_S - NSLV'(1))) != '0);

    always_comb begin
        w_setup_idx = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (PSEL_S[i]) w_setup_idx = IW'(i);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_decerr  <= 1'b0;
            r_wcnt    <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_decerr <= w_decerr_nxt;
            r_wcnt   <= w_wcnt_nxt;
            if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_decerr_nxt = r_decerr;
        w_wcnt_nxt   = r_wcnt;
        w_err_inc    = 1'b0;
        PREADY       = 1'b0;
        PSLVERR      = 1'b0;
        PRDATA       = '0;
        TO_PULSE     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_idx_nxt    = w_setup_idx;
                    w_decerr_nxt = w_setup_decerr;
                    w_wcnt_nxt   = '0;
                    w_state_nxt  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!w_active) begin
                    // Master abandoned the transfer; drop it without counting an error.
                    w_wcnt_nxt   = '0;
                    w_decerr_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else if (r_decerr) begin
                    PREADY       = 1'b1;
                    PSLVERR      = 1'b1;
                    w_err_inc    = 1'b1;
                    w_decerr_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else if (w_sel_rdy) begin
                    // Slave readiness beats a timeout landing in the same cycle.
                    PREADY      = 1'b1;
                    PSLVERR     = w_sel_err;
                    PRDATA      = w_sel_data;
                    w_state_nxt = S_IDLE;
                end else if (r_wcnt == 8'(TIMEOUT)) begin
                    PREADY      = 1'b1;
                    PSLVERR     = 1'b1;
                    TO_PULSE    = 1'b1;
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_ABORT;
                end else begin
                    w_wcnt_nxt = r_wcnt + 8'd1;
                end
            end
            S_ABORT: begin
                if (w_setup) begin
                    w_idx_nxt    = w_setup_idx;
                    w_decerr_nxt = w_setup_decerr;
                    w_wcnt_nxt   = '0;
                    w_state_nxt  = S_ACCESS;
                end else if (!PSEL) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The timed-out slave is still mid-transfer, so it is kept deselected until the master moves on.
    assign PSEL_G  = (PRESETn && (r_state != S_ABORT) && !r_decerr) ? (PSEL_S & {NSLV{PSEL}}) : '0;
    assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_apb_resp_mux.sv
// Bench for apb_resp_mux: directed cycle table, directed corner sequences and random
// transfers checked against a transfer-level model of the expected response.
module tb_apb_resp_mux;
    localparam int TIMEOUT = 16;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic [1:0]  PSEL_S;
    logic [1:0]  PREADY_S;
    logic [1:0]  PSLVERR_S;
    logic [63:0] PRDATA_S;
    logic [1:0]  PSEL_G;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PRDATA;
    logic        TO_PULSE;
    logic [7:0]  ERR_CNT;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    bit abort_prev = 0;

    apb_resp_mux #(.NSLV(2), .TIMEOUT(TIMEOUT)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PSEL_S    (PSEL_S),
        .PREADY_S  (PREADY_S),
        .PSLVERR_S (PSLVERR_S),
        .PRDATA_S  (PRDATA_S),
        .PSEL_G    (PSEL_G),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .PRDATA    (PRDATA),
        .TO_PULSE  (TO_PULSE),
        .ERR_CNT   (ERR_CNT)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        psel;
        logic        pen;
        logic [1:0]  sel;
        logic [1:0]  rdy;
        logic [1:0]  serr;
        logic [1:0]  g;
        logic        ordy;
        logic        oerr;
        logic [31:0] odata;
        logic        oto;
        logic [7:0]  ocnt;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // One complete master transfer; expected response derived from the transfer's parameters.
    task automatic run_xfer(input logic [1:0] sel, input int delay, input logic serr,
                            input logic [31:0] data, input bit gap);
        bit          dec;
        int          idx;
        int          ecyc;
        logic        eerr;
        logic [31:0] edata;
        logic        eto;
        bit          done;
        dec = ($countones(sel) != 1);
        idx = sel[1] ? 1 : 0;
        if (dec) begin
            ecyc = 1; eerr = 1'b1; edata = 32'd0; eto = 1'b0;
        end else if (delay <= TIMEOUT) begin
            ecyc = delay + 1; eerr = serr; edata = data; eto = 1'b0;
        end else begin
            ecyc = TIMEOUT + 1; eerr = 1'b1; edata = 32'd0; eto = 1'b1;
        end
        PSEL = 1'b1; PENABLE = 1'b0; PSEL_S = sel;
        PREADY_S = 2'($urandom); PSLVERR_S = 2'($urandom); PRDATA_S = {$urandom, $urandom};
        @(negedge PCLK);
        chk("setup_pready", 32'(PREADY), 32'd0);
        chk("setup_pselg", 32'(PSEL_G), 32'(abort_prev ? 2'b00 : sel));
        chk("setup_errcnt", 32'(ERR_CNT), 32'(exp_cnt));
        step();
        done = 0;
        for (int k = 1; k <= TIMEOUT + 3 && !done; k++) begin
            PENABLE = 1'b1;
            PREADY_S = 2'($urandom); PSLVERR_S = 2'($urandom); PRDATA_S = {$urandom, $urandom};
            if (!dec) begin
                PREADY_S[idx]        = (k - 1 >= delay);
                PSLVERR_S[idx]       = serr;
                PRDATA_S[32*idx +: 32] = data;
            end
            @(negedge PCLK);
            chk("acc_pselg", 32'(PSEL_G), 32'(dec ? 2'b00 : sel));
            if (PREADY) begin
                done = 1;
                chk("resp_cycle", 32'(k), 32'(ecyc));
                chk("resp_pslverr", 32'(PSLVERR), 32'(eerr));
                chk("resp_prdata", PRDATA, edata);
                chk("resp_to_pulse", 32'(TO_PULSE), 32'(eto));
            end else begin
                chk("wait_to_pulse", 32'(TO_PULSE), 32'd0);
            end
            step();
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL resp_timeout: got no PREADY want PREADY by cycle %0d", ecyc);
        end
        abort_prev = eto;
        if ((dec || eto) && exp_cnt < 255) exp_cnt++;
        if (gap) begin
            PSEL = 1'b0; PENABLE = 1'b0; PSEL_S = 2'($urandom);
            @(negedge PCLK);
            chk("gap_pready", 32'(PREADY), 32'd0);
            chk("gap_pselg", 32'(PSEL_G), 32'd0);
            step();
            abort_prev = 0;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b1, 2'b01, 2'b01, 2'b10, 2'b01, 1'b1, 1'b0, 32'h5A5A_0000, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0};
        tbl[7]  = '{1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1, 32'h0,         1'b0, 8'd0};
        tbl[8]  = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 8'd1};
        tbl[9]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 8'd1};
        tbl[10] = '{1'b1, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 32'h0,         1'b0, 8'd1};
        tbl[11] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 8'd2};
        tbl[12] = '{1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0,         1'b0, 8'd2};
        tbl[13] = '{1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 8'd2};
        tbl[14] = '{1'b1, 1'b1, 2'b10, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0,         1'b0, 8'd2};
        tbl[15] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 8'd2};

        // Reset: outputs quiet even with a select and ready presented.
        PRESETn = 1'b0; PSEL = 1'b1; PENABLE = 1'b0; PSEL_S = 2'b01;
        PREADY_S = 2'b11; PSLVERR_S = 2'b11; PRDATA_S = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        #3;
        chk("rst_pselg", 32'(PSEL_G), 32'd0);
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_to_pulse", 32'(TO_PULSE), 32'd0);
        chk("rst_errcnt", 32'(ERR_CNT), 32'd0);
        step();
        PRESETn = 1'b1;

        // Slave 1 ready after two waits, first setup right after reset release.
        run_xfer(2'b10, 2, 1'b0, 32'hA5A5_0001, 1);
        chk("r35_errcnt", 32'(ERR_CNT), 32'd0);

        PRDATA_S = {32'hA5A5_0001, 32'h5A5A_0000};
        for (int i = 0; i < 16; i++) begin
            PSEL = tbl[i].psel; PENABLE = tbl[i].pen; PSEL_S = tbl[i].sel;
            PREADY_S = tbl[i].rdy; PSLVERR_S = tbl[i].serr;
            @(negedge PCLK);
            chk($sformatf("tbl%0d_pselg", i), 32'(PSEL_G), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_pready", i), 32'(PREADY), 32'(tbl[i].ordy));
            chk($sformatf("tbl%0d_pslverr", i), 32'(PSLVERR), 32'(tbl[i].oerr));
            chk($sformatf("tbl%0d_prdata", i), PRDATA, tbl[i].odata);
            chk($sformatf("tbl%0d_to", i), 32'(TO_PULSE), 32'(tbl[i].oto));
            chk($sformatf("tbl%0d_errcnt", i), 32'(ERR_CNT), 32'(tbl[i].ocnt));
            step();
        end
        exp_cnt = 2;

        // Empty select answered locally.
        run_xfer(2'b00, 0, 1'b0, 32'h0, 1);
        chk("r36_errcnt", 32'(ERR_CNT), 32'd3);

        // Slave 0 never ready: abort, master lingers one cycle, then a setup straight out of ABORT.
        run_xfer(2'b01, TIMEOUT + 5, 1'b0, 32'h0, 0);
        PSEL = 1'b1; PENABLE = 1'b1; PSEL_S = 2'b01; PREADY_S = 2'b11; PSLVERR_S = 2'b00;
        @(negedge PCLK);
        chk("abort_pselg", 32'(PSEL_G), 32'd0);
        chk("abort_pready", 32'(PREADY), 32'd0);
        chk("abort_to_pulse", 32'(TO_PULSE), 32'd0);
        chk("abort_errcnt", 32'(ERR_CNT), 32'd4);
        step();
        run_xfer(2'b10, 0, 1'b0, 32'hCAFE_0010, 1);

        // Ready in the exact timeout cycle, with slave error: no timeout, no count.
        run_xfer(2'b10, TIMEOUT, 1'b1, 32'h1234_5678, 1);
        chk("r38_errcnt", 32'(ERR_CNT), 32'd4);

        // Reset in the 5th wait cycle.
        PSEL = 1'b1; PENABLE = 1'b0; PSEL_S = 2'b10; PREADY_S = 2'b00;
        step();
        PENABLE = 1'b1;
        for (int k = 0; k < 4; k++) step();
        #2;
        PRESETn = 1'b0;
        #1;
        chk("midrst_pselg", 32'(PSEL_G), 32'd0);
        chk("midrst_pready", 32'(PREADY), 32'd0);
        chk("midrst_errcnt", 32'(ERR_CNT), 32'd0);
        PREADY_S = 2'b11; PSLVERR_S = 2'b11;
        #1;
        chk("midrst_pready2", 32'(PREADY), 32'd0);
        chk("midrst_to_pulse", 32'(TO_PULSE), 32'd0);
        step();
        PRESETn = 1'b1;
        exp_cnt = 0; abort_prev = 0;
        run_xfer(2'b10, 1, 1'b0, 32'hBEEF_0040, 1);

        // Random transfers.
        for (int n = 0; n < 80; n++) begin
            logic [1:0] rs;
            int         rd;
            rs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) rd = $urandom_range(0, 3);
            else rd = $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
            run_xfer(rs, rd, 1'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)));
        end
        if (abort_prev) begin
            PSEL = 1'b0; PENABLE = 1'b0;
            step();
            abort_prev = 0;
        end

        // Saturation of the error counter.
        for (int n = 0; n < 260; n++) run_xfer(2'b00, 0, 1'b0, 32'h0, 0);
        PSEL = 1'b0; PENABLE = 1'b0;
        step();
        chk("sat_errcnt", 32'(ERR_CNT), 32'd255);
        step();
        chk("sat_hold", 32'(ERR_CNT), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
